// File: rtl/parity_stream_acc_if.sv
// Word-stream and frame-result channels of the streaming parity accumulator.
interface parity_stream_acc_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             odd_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;

  modport master (
    output in_valid, in_data, in_last, odd_mode, out_ready,
    input  in_ready, out_valid, out_parity, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, odd_mode, out_ready,
    output in_ready, out_valid, out_parity, out_count, out_sat
  );
endinterface

// File: rtl/parity_stream_acc.sv
// Streaming parity engine: folds each word to one parity bit, accumulates it over
// an in_last-delimited frame and presents parity plus saturating word count.
module parity_stream_acc #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parity_stream_acc_if.slave   bus
);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             mode_q, mode_d;

  logic             out_valid_q, out_valid_d;
  logic             out_parity_q, out_parity_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_sat_q, out_sat_d;

  logic wp;
  logic accept;
  logic close;
  logic mode_eff;

  assign wp = ^bus.in_data;

  // Only a closing word can be blocked by a stalled result; other words always flow.
  assign bus.in_ready = !(out_valid_q && !bus.out_ready) || !(bus.in_valid && bus.in_last);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    mode_d   = mode_q;
    mode_eff = mode_q;
    close    = 1'b0;
    if (accept) begin
      if (state_q == IDLE) begin
        mode_d   = bus.odd_mode;
        mode_eff = bus.odd_mode;
        acc_d    = wp;
        cnt_d    = CNT_W'(1);
        sat_d    = 1'b0;
        state_d  = ACCUM;
      end else begin
        acc_d = acc_q ^ wp;
        if (cnt_q == '1) begin
          sat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      if (bus.in_last) begin
        close   = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_parity_d = out_parity_q;
    out_count_d  = out_count_q;
    out_sat_d    = out_sat_q;
    if (close) begin
      out_valid_d  = 1'b1;
      out_parity_d = acc_d ^ mode_eff;
      out_count_d  = cnt_d;
      out_sat_d    = sat_d;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      sat_q        <= 1'b0;
      mode_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
      out_count_q  <= '0;
      out_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      sat_q        <= sat_d;
      mode_q       <= mode_d;
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
      out_count_q  <= out_count_d;
      out_sat_q    <= out_sat_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_parity = out_parity_q;
  assign bus.out_count  = out_count_q;
  assign bus.out_sat    = out_sat_q;

endmodule

// File: doc/parity_stream_acc.md
# parity_stream_acc

- Streaming, parametrised parity engine; successor to the team's fixed 16-input combinational parity function.
- Accepts WIDTH-bit words over a valid/ready handshake and reduces each word to one parity bit.
- Accumulates that bit across a frame delimited by `in_last`, then presents the frame's even- or odd-parity bit and word count on a registered, back-pressured output.
- Sits between a packet source and the integrity-check/CRC stage of the datapath.

## Interface

Parameters:
- WIDTH, 16 — data word width in bits, ≥ 1.
- CNT_W, 8 — width of the frame word counter, ≥ 1.

Ports:
- clk  in  1  — single clock; all state updates on its rising edge.
- rst_n  in  1  — reset, asynchronous and active-low.
- in_valid  in  1  — input word valid.
- in_ready  out  1  — block can accept a word.
- in_data  in  WIDTH  — input word.
- in_last  in  1  — qualifies the final word of a frame.
- odd_mode  in  1  — 0 = even parity, 1 = odd parity; sampled on the first word of each frame.
- out_valid  out  1  — frame result valid.
- out_ready  in  1  — downstream accepts the result.
- out_parity  out  1  — frame parity bit.
- out_count  out  CNT_W  — number of words in the frame, saturating.
- out_sat  out  1  — the frame word count exceeded 2^CNT_W − 1.

## Operation

- Handshakes:
  - An input word is accepted when `in_valid && in_ready`.
  - A result is taken when `out_valid && out_ready`.
- Word parity `wp = ^in_data` (XOR of all WIDTH bits).
- State machine:
  - IDLE: no frame open. An accepted word opens a frame.
    - Latch `mode <= odd_mode`.
    - Set `acc <= wp`, `cnt <= 1`, `sat <= 0`.
    - If `in_last` is also set, the frame closes immediately (single-word frame) and the state stays IDLE. Otherwise go to ACCUM.
  - ACCUM: on each accepted word, `acc <= acc ^ wp`.
    - `cnt` increments by 1 but saturates at 2^CNT_W − 1.
    - An increment attempted while `cnt` is at max sets `sat`.
    - `odd_mode` is ignored while in ACCUM.
    - An accepted word with `in_last` closes the frame and returns to IDLE.
- Frame close:
  - Load `out_parity <= acc_next ^ mode_eff`, where `mode_eff` is `odd_mode` for a single-word frame and the latched `mode` otherwise.
  - Load `out_count <= cnt_next` and `out_sat <= sat_next`.
  - Set `out_valid <= 1`.
- Even mode: `out_parity` = 1 iff the frame has an odd number of 1 bits, so the frame plus the parity bit has even weight. Odd mode inverts this.
- Output register:
  - `out_valid` and the result fields hold stable until the result is taken.
  - The result fields do not change while `out_valid && !out_ready`.
- `in_ready = !out_valid || out_ready`, combinational from `out_ready` and registered `out_valid`. No skid buffer.
- Only a frame close stalls the input. Non-last words are accepted regardless of `out_valid`.
  - Stated exactly: `in_ready = !(out_valid && !out_ready) || !pending_close`.
  - `pending_close = in_valid && in_last`.
- Simultaneous events:
  - Result taken and a new frame closed in the same cycle: the new result loads and `out_valid` stays 1.
  - Result taken with no new close: `out_valid` drops to 0.
- `in_valid` low stalls accumulation. State and counters hold indefinitely.
- An `in_last` word with `in_valid` low has no effect.

## Timing

- Latency: the last word is accepted in cycle N; `out_valid` and the result are visible in cycle N+1.
- Throughput: one word per cycle, including back-to-back frames and single-word frames, provided `out_ready` is high.
- Reset values:
  - `out_valid` = 0, `out_parity` = 0, `out_count` = 0, `out_sat` = 0.
  - State IDLE; `acc`, `cnt`, `sat`, `mode` all 0.
  - `in_ready` = 1 while `rst_n` = 0.
- Reset mid-frame: the partial frame is discarded and no result is emitted. The first accepted word after release starts a new frame.
- Counter wrap: `cnt` never wraps; it saturates, and `out_sat` flags it.

## Test plan

- Single-word frame, WIDTH=16, 0x0001, `in_last`=1, `odd_mode`=0 → next cycle `out_valid`=1, `out_parity`=1, `out_count`=1, `out_sat`=0. The same word with `odd_mode`=1 → `out_parity`=0.
- Three-word frame 0xFFFF, 0x0001, 0x0003 (19 ones), even mode, with `odd_mode` toggled to 1 on words 2–3 → `out_parity`=1 and `out_count`=3. The latched mode is unaffected by the toggle.
- Backpressure:
  - Stimulus: one frame's result pending, `out_ready`=0 for 3 cycles, next frame's last word presented.
  - Required: `in_ready`=0 for those 3 cycles and `out_parity`/`out_count` stable.
  - Then `out_ready`=1: that cycle both handshakes complete, and `out_valid` stays 1 with the new result.
- Back-to-back single-word frames 0x0000, 0x0007, 0x8001 with `out_ready`=1 → results 0, 1, 0 on three consecutive cycles, and `in_ready` never low.
- Saturation, CNT_W=2: a 5-word frame of 0x0001 → `out_count`=3, `out_sat`=1, `out_parity`=1. The following 2-word frame → `out_sat`=0.
- Reset mid-frame: 2 words of a 4-word frame, then `rst_n` pulsed low asynchronously between edges → all outputs 0 immediately. A subsequent 1-word frame 0x0003 → `out_parity`=0, `out_count`=1.
